// File: rtl/riscv_rv12_pkg.sv
// Shared RV12 core definitions used by the data-memory TCM.
// - Load/store size encodings carried on dmem_size.
// - size2be: byte enables for a size and the byte offset within the word.
// - is_misaligned: alignment check for a size and the byte offset.
// - dmem_state_e: state encoding of the TCM access sequencer.
package riscv_rv12_pkg;

  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HWORD  = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] DWORD  = 3'b011;
  localparam logic [2:0] UBYTE  = 3'b100;
  localparam logic [2:0] UHWORD = 3'b101;
  localparam logic [2:0] UWORD  = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } dmem_state_e;

  function automatic logic [3:0] size2be(input logic [2:0] size, input logic [1:0] adr);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      BYTE, UBYTE:   be = 4'b0001 << adr;
      HWORD, UHWORD: be = adr[1] ? 4'b1100 : 4'b0011;
      WORD, UWORD:   be = 4'b1111;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  // DWORD and the unused encoding can never be served by a 32-bit RAM.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] adr);
    logic mis;
    mis = 1'b1;
    case (size)
      BYTE, UBYTE:   mis = 1'b0;
      HWORD, UHWORD: mis = adr[0];
      WORD, UWORD:   mis = |adr;
      default:       mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read.
// Read-during-write returns the word as it was before the write.
// Ports:
//   clk   - clock
//   en    - access enable (read always, write when we)
//   we    - write enable
//   be    - byte lane enables for the write
//   addr  - word index
//   wdata - write data
//   rdata - registered read data
module riscv_dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: contents survive a core reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data-memory responder for the core's dmem bus.
// Accepts one access at a time, checks alignment and address window, performs it against
// riscv_dmem_ram and acknowledges WAIT_STATES+1 cycles after capture.
// Ports:
//   rstn, clk        - synchronous active-low reset, rising-edge clock
//   dmem_req         - request, held until dmem_ack
//   dmem_adr         - byte address
//   dmem_we          - 1 store, 0 load
//   dmem_size        - access size (riscv_rv12_pkg encoding)
//   dmem_d           - lane-positioned store data
//   dmem_q           - raw RAM word (pre-write word for stores), 0 outside ack or on fault
//   dmem_ack         - one-cycle completion strobe
//   dmem_misaligned  - alignment fault, valid with ack
//   dmem_page_fault  - out-of-window fault, valid with ack
module riscv_dmem_tcm
  import riscv_rv12_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] BASE        = '0,
  parameter int unsigned     DEPTH       = 1024,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_size,
  input  logic [XLEN-1:0] dmem_d,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam bit          NoWait   = (WAIT_STATES == 0);
  localparam logic [3:0]  WaitInit = NoWait ? 4'd0 : 4'(WAIT_STATES - 1);

  if (XLEN != 32) begin : gen_xlen_check
    $error("riscv_dmem_tcm: only XLEN=32 is supported");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("riscv_dmem_tcm: DEPTH must be a power of 2 and at least 2");
  end
  if (WAIT_STATES > 15) begin : gen_wait_check
    $error("riscv_dmem_tcm: WAIT_STATES must be 0..15");
  end

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] d_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic            mis_q, pf_q;

  // Offset into the window; BASE is window-aligned so its low bits are the byte lane.
  logic [XLEN-1:0] off;
  logic            mis_in, pf_in;
  logic [3:0]      be_in;
  logic            capture;

  assign off     = dmem_adr - BASE;
  assign mis_in  = is_misaligned(dmem_size, off[1:0]);
  assign pf_in   = !mis_in && (off[XLEN-1:AW+2] != '0);
  assign be_in   = size2be(dmem_size, off[1:0]);
  assign capture = (state_q == StIdle) && dmem_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (dmem_req) begin
          state_d = NoWait ? StAck : StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      mis_q   <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q <= off[AW+1:2];
        d_q   <= dmem_d;
        we_q  <= dmem_we;
        be_q  <= be_in;
        mis_q <= mis_in;
        pf_q  <= pf_in;
      end
    end
  end

  // The RAM is accessed on the edge that enters ACK. Without wait states that edge is the
  // capture edge itself, so the live request drives the port instead of the captured copy.
  logic            ram_en, ram_we;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wdata, ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = we_q;
    ram_be    = be_q;
    ram_addr  = idx_q;
    ram_wdata = d_q;
    if (NoWait && capture) begin
      ram_en    = !mis_in && !pf_in;
      ram_we    = dmem_we;
      ram_be    = be_in;
      ram_addr  = off[AW+1:2];
      ram_wdata = dmem_d;
    end else if (state_q == StWait && cnt_q == 4'd0) begin
      ram_en = !mis_q && !pf_q;
    end
    // A store whose ACK-entry edge meets reset must not land.
    ram_en = ram_en && rstn;
  end

  riscv_dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign dmem_ack        = (state_q == StAck);
  assign dmem_misaligned = dmem_ack && mis_q;
  assign dmem_page_fault = dmem_ack && pf_q;
  assign dmem_q          = (dmem_ack && !mis_q && !pf_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Directed bench for riscv_dmem_tcm: three instances with 0, 3 and 5 wait states
// sharing the request attributes, each with its own request line.
module tb_riscv_dmem_tcm;
  import riscv_rv12_pkg::*;

  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [31:0] adr = '0;
  logic        we = 1'b0;
  logic [2:0]  size = WORD;
  logic [31:0] d = '0;

  logic [31:0] q0, q1, q2;
  logic        ack0, ack1, ack2;
  logic        mis0, mis1, mis2;
  logic        pf0, pf1, pf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_tcm #(.XLEN(32), .BASE(Base), .DEPTH(Depth), .WAIT_STATES(0)) u_dut0 (
    .rstn(rstn), .clk(clk), .dmem_req(req0), .dmem_adr(adr), .dmem_we(we), .dmem_size(size),
    .dmem_d(d), .dmem_q(q0), .dmem_ack(ack0), .dmem_misaligned(mis0), .dmem_page_fault(pf0)
  );
  riscv_dmem_tcm #(.XLEN(32), .BASE(Base), .DEPTH(Depth), .WAIT_STATES(3)) u_dut1 (
    .rstn(rstn), .clk(clk), .dmem_req(req1), .dmem_adr(adr), .dmem_we(we), .dmem_size(size),
    .dmem_d(d), .dmem_q(q1), .dmem_ack(ack1), .dmem_misaligned(mis1), .dmem_page_fault(pf1)
  );
  riscv_dmem_tcm #(.XLEN(32), .BASE(Base), .DEPTH(Depth), .WAIT_STATES(5)) u_dut2 (
    .rstn(rstn), .clk(clk), .dmem_req(req2), .dmem_adr(adr), .dmem_we(we), .dmem_size(size),
    .dmem_d(d), .dmem_q(q2), .dmem_ack(ack2), .dmem_misaligned(mis2), .dmem_page_fault(pf2)
  );

  function automatic logic [34:0] outs_of(input int inst);
    case (inst)
      0:       return {ack0, mis0, pf0, q0};
      1:       return {ack1, mis1, pf1, q1};
      default: return {ack2, mis2, pf2, q2};
    endcase
  endfunction

  task automatic set_req(input int inst, input logic v);
    case (inst)
      0:       req0 = v;
      1:       req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one access, returns the ack-cycle outputs, latency in cycles from capture and the
  // ack value one cycle later. With hold, req stays high across the ACK-exit edge.
  task automatic access(input int inst, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] q, output logic m, output logic p,
                        output int lat, output logic ack_after);
    logic [34:0] o;
    @(negedge clk);
    adr = a; we = w; size = sz; d = wd;
    set_req(inst, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      o = outs_of(inst);
    end while (!o[34] && lat < 40);
    q = o[31:0]; m = o[33]; p = o[32];
    if (!hold) set_req(inst, 1'b0);
    @(negedge clk);
    o = outs_of(inst);
    ack_after = o[34];
    set_req(inst, 1'b0);
  endtask

  logic [31:0] q;
  logic        m, p, aa;
  int          lat;
  logic [34:0] o;
  int          seen;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs0", {29'd0, outs_of(0)[34:32]}, 32'd0);
    chk("rst_q0", outs_of(0)[31:0], 32'd0);
    chk("rst_outs1", {29'd0, outs_of(1)[34:32]}, 32'd0);
    chk("rst_outs2", {29'd0, outs_of(2)[34:32]}, 32'd0);
    rstn = 1'b1;

    // WAIT_STATES=0: word store then load
    access(0, 1'b1, WORD, Base + 32'd8, 32'hDEAD_BEEF, 1'b0, q, m, p, lat, aa);
    chk("st_lat", lat, 32'd1);
    chk("st_flags", {30'd0, m, p}, 32'd0);
    chk("st_ack_once", {31'd0, aa}, 32'd0);
    access(0, 1'b0, WORD, Base + 32'd8, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("ld_lat", lat, 32'd1);
    chk("ld_q", q, 32'hDEAD_BEEF);

    // Byte store into a known word; store returns the pre-write word
    access(0, 1'b1, WORD, Base + 32'd4, 32'h1122_3344, 1'b0, q, m, p, lat, aa);
    access(0, 1'b1, BYTE, Base + 32'd6, 32'h00AA_0000, 1'b0, q, m, p, lat, aa);
    chk("stb_prewrite_q", q, 32'h1122_3344);
    access(0, 1'b0, WORD, Base + 32'd4, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("ldb_q", q, 32'h11AA_3344);

    // Misaligned halfword load
    access(0, 1'b0, HWORD, Base + 32'd3, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("mis_h_flags", {30'd0, m, p}, 32'd2);
    chk("mis_h_q", q, 32'd0);
    // Misaligned word store must not write; DWORD always faults
    access(0, 1'b1, WORD, Base + 32'd6, 32'hFFFF_FFFF, 1'b0, q, m, p, lat, aa);
    chk("mis_w_flags", {30'd0, m, p}, 32'd2);
    access(0, 1'b0, DWORD, Base + 32'd0, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("mis_d_flags", {30'd0, m, p}, 32'd2);
    access(0, 1'b0, UHWORD, Base + 32'd6, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("ld_uh_q", q, 32'h11AA_3344);
    chk("ld_uh_flags", {30'd0, m, p}, 32'd0);

    // Page faults above and below the window; word 0 untouched by the wrap alias
    access(0, 1'b1, WORD, Base, 32'h5566_7788, 1'b0, q, m, p, lat, aa);
    access(0, 1'b1, WORD, Base + Depth * 4, 32'hCAFE_F00D, 1'b0, q, m, p, lat, aa);
    chk("pf_hi_flags", {30'd0, m, p}, 32'd1);
    chk("pf_hi_q", q, 32'd0);
    access(0, 1'b0, WORD, Base - 32'd4, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("pf_lo_flags", {30'd0, m, p}, 32'd1);
    access(0, 1'b0, WORD, Base, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("pf_nowrap_q", q, 32'h5566_7788);

    // Store whose capture/ACK-entry edge coincides with reset is dropped
    @(negedge clk);
    adr = Base + 32'd8; we = 1'b1; size = WORD; d = 32'h0; req0 = 1'b1; rstn = 1'b0;
    @(negedge clk);
    req0 = 1'b0; rstn = 1'b1;
    chk("rst_st_ack", {31'd0, ack0}, 32'd0);
    access(0, 1'b0, WORD, Base + 32'd8, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("rst_st_nowrite", q, 32'hDEAD_BEEF);

    // WAIT_STATES=3, req held through the ACK-exit edge
    access(1, 1'b1, WORD, Base + 32'h10, 32'hA5A5_A5A5, 1'b1, q, m, p, lat, aa);
    chk("ws3_lat", lat, 32'd4);
    chk("ws3_ack_once", {31'd0, aa}, 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack1) seen++;
    end
    chk("ws3_no_recapture", seen, 32'd0);
    access(1, 1'b0, WORD, Base + 32'h10, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("ws3_ld_lat", lat, 32'd4);
    chk("ws3_ld_q", q, 32'hA5A5_A5A5);

    // WAIT_STATES=5, reset one cycle after capture
    @(negedge clk);
    adr = Base; we = 1'b1; size = WORD; d = 32'h0000_0001; req2 = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; req2 = 1'b0;
    seen = 0;
    repeat (10) begin
      o = outs_of(2);
      if (o !== 35'd0) seen++;
      @(negedge clk);
    end
    chk("ws5_rst_outs", seen, 32'd0);
    access(2, 1'b1, WORD, Base, 32'h1234_5678, 1'b0, q, m, p, lat, aa);
    chk("ws5_st_lat", lat, 32'd6);
    access(2, 1'b0, WORD, Base, 32'h0, 1'b0, q, m, p, lat, aa);
    chk("ws5_ld_lat", lat, 32'd6);
    chk("ws5_ld_q", q, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
